// File: rtl/pmbist_pkg.sv
// Shared PMBIST types: analyzer FSM states, delay-line payload layout and read-latency limits.
package pmbist_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAddrWidth = 12;

  localparam int unsigned ReadLatencyMin = 1;
  localparam int unsigned ReadLatencyMax = 4;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDrain,
    StDone
  } bist_state_e;

  // Payload at the default widths; blocks built at other widths declare the same field order.
  typedef struct packed {
    logic                    valid;
    logic [DefAddrWidth-1:0] addr;
    logic [DefDataWidth-1:0] exp;
    logic [DefDataWidth-1:0] mask;
  } dl_payload_t;

endpackage

// File: rtl/bist_delay_line.sv
// Width x Depth shift register with asynchronous active-low clear and synchronous flush.
// Shared by the response analyzer (compare alignment) and the sequencer (address pipelining).
module bist_delay_line #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_stage [Depth];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(Depth); i++) r_stage[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < int'(Depth); i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(Depth); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[Depth-1];

endmodule

// File: rtl/bist_response_analyzer.sv
// PMBIST response analyzer: aligns expected data to memory read latency and accumulates results.
// Define PMBIST_FIRST_FAIL_CAPTURE_EN to build the first-failure capture registers (ff_*).
module bist_response_analyzer
  import pmbist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_end_test,
  input  logic                  i_cmp_en,
  input  logic [ADDR_WIDTH-1:0] i_addr_in,
  input  logic [DATA_WIDTH-1:0] i_exp_data,
  input  logic [DATA_WIDTH-1:0] i_cmp_mask,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fail,
  output logic                  o_fail_pulse,
  output logic [CNT_WIDTH-1:0]  o_fail_count,
  output logic [DATA_WIDTH-1:0] o_fail_bits,
  output logic [ADDR_WIDTH-1:0] o_ff_addr,
  output logic [DATA_WIDTH-1:0] o_ff_exp,
  output logic [DATA_WIDTH-1:0] o_ff_act
);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] exp;
    logic [DATA_WIDTH-1:0] mask;
  } payload_t;

  localparam int unsigned DrainCntWidth = $clog2(ReadLatencyMax + 2);
  // DRAIN spans READ_LATENCY+1 cycles so the last compare's result is visible before done.
  localparam logic [DrainCntWidth-1:0] DrainLast = DrainCntWidth'(READ_LATENCY);

  if (READ_LATENCY < ReadLatencyMin || READ_LATENCY > ReadLatencyMax) begin : g_bad_latency
    $error("bist_response_analyzer: READ_LATENCY outside legal range");
  end

  bist_state_e              r_state;
  bist_state_e              w_state_next;
  logic [DrainCntWidth-1:0] r_drain_cnt;

  payload_t                 w_dl_d;
  payload_t                 w_dl_q;
  logic [DATA_WIDTH-1:0]    w_mismatch;
  logic                     w_hit;

  logic                     r_fail;
  logic                     r_fail_pulse;
  logic [CNT_WIDTH-1:0]     r_fail_count;
  logic [DATA_WIDTH-1:0]    r_fail_bits;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= (r_state == StDrain) ? r_drain_cnt + 1'b1 : '0;
    end
  end

  // FSM next state; start wins over end_test
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (i_start) w_state_next = StActive;
      StActive: begin
        if (i_start)         w_state_next = StActive;
        else if (i_end_test) w_state_next = StDrain;
      end
      StDrain: begin
        if (i_start)                       w_state_next = StActive;
        else if (r_drain_cnt == DrainLast) w_state_next = StDone;
      end
      StDone:   if (i_start) w_state_next = StActive;
      default:  w_state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy = (r_state == StActive) || (r_state == StDrain);
    o_done = (r_state == StDone);
  end

  assign w_dl_d = '{
    valid: i_cmp_en && !i_start && (r_state == StActive),
    addr:  i_addr_in,
    exp:   i_exp_data,
    mask:  i_cmp_mask
  };

  bist_delay_line #(
    .Width($bits(payload_t)),
    .Depth(READ_LATENCY)
  ) u_delay_line (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_start),
    .i_d     (w_dl_d),
    .o_q     (w_dl_q)
  );

  assign w_mismatch = (i_mem_data ^ w_dl_q.exp) & ~w_dl_q.mask;
  assign w_hit      = w_dl_q.valid && (|w_mismatch);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fail       <= 1'b0;
      r_fail_pulse <= 1'b0;
      r_fail_count <= '0;
      r_fail_bits  <= '0;
    end else if (i_start) begin
      r_fail       <= 1'b0;
      r_fail_pulse <= 1'b0;
      r_fail_count <= '0;
      r_fail_bits  <= '0;
    end else begin
      r_fail_pulse <= w_hit;
      if (w_hit) begin
        r_fail      <= 1'b1;
        r_fail_bits <= r_fail_bits | w_mismatch;
        if (r_fail_count != '1) r_fail_count <= r_fail_count + 1'b1;
      end
    end
  end

  assign o_fail       = r_fail;
  assign o_fail_pulse = r_fail_pulse;
  assign o_fail_count = r_fail_count;
  assign o_fail_bits  = r_fail_bits;

`ifdef PMBIST_FIRST_FAIL_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] r_ff_addr;
  logic [DATA_WIDTH-1:0] r_ff_exp;
  logic [DATA_WIDTH-1:0] r_ff_act;

  // r_fail still low means this hit is the first of the session
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ff_addr <= '0;
      r_ff_exp  <= '0;
      r_ff_act  <= '0;
    end else if (i_start) begin
      r_ff_addr <= '0;
      r_ff_exp  <= '0;
      r_ff_act  <= '0;
    end else if (w_hit && !r_fail) begin
      r_ff_addr <= w_dl_q.addr;
      r_ff_exp  <= w_dl_q.exp;
      r_ff_act  <= i_mem_data;
    end
  end

  assign o_ff_addr = r_ff_addr;
  assign o_ff_exp  = r_ff_exp;
  assign o_ff_act  = r_ff_act;
`else
  logic [ADDR_WIDTH-1:0] w_unused_addr;
  assign w_unused_addr = w_dl_q.addr;

  assign o_ff_addr = '0;
  assign o_ff_exp  = '0;
  assign o_ff_act  = '0;
`endif

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer: two instances (latency 1 / 16-bit count, latency 3 / 4-bit
// count) share stimulus; a cycle-indexed reference model plus a vector table check the results.
module tb_bist_response_analyzer;

`ifdef PMBIST_FIRST_FAIL_CAPTURE_EN
  localparam bit FfEn = 1'b1;
`else
  localparam bit FfEn = 1'b0;
`endif

  localparam logic [2:0] NOP = 3'b000;
  localparam logic [2:0] CE  = 3'b001;
  localparam logic [2:0] ET  = 3'b010;
  localparam logic [2:0] ST  = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        t_start, t_end, t_cmp;
  logic [11:0] t_addr;
  logic [7:0]  t_exp, t_mask, t_act;
  logic [7:0]  hist [3];

  logic        a_busy, a_done, a_fail, a_pulse;
  logic [15:0] a_cnt;
  logic [7:0]  a_bits, a_ffe, a_ffo;
  logic [11:0] a_ffa;
  logic        b_busy, b_done, b_fail, b_pulse;
  logic [3:0]  b_cnt;
  logic [7:0]  b_bits, b_ffe, b_ffo;
  logic [11:0] b_ffa;

  always #5 clk = ~clk;

  // Memory model: data returned for a read issued at cycle N appears READ_LATENCY cycles later.
  always @(posedge clk) begin
    hist[0] <= t_act;
    hist[1] <= hist[0];
    hist[2] <= hist[1];
  end

  bist_response_analyzer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(12), .READ_LATENCY(1), .CNT_WIDTH(16)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(t_start), .i_end_test(t_end), .i_cmp_en(t_cmp),
    .i_addr_in(t_addr), .i_exp_data(t_exp), .i_cmp_mask(t_mask), .i_mem_data(hist[0]),
    .o_busy(a_busy), .o_done(a_done), .o_fail(a_fail), .o_fail_pulse(a_pulse),
    .o_fail_count(a_cnt), .o_fail_bits(a_bits), .o_ff_addr(a_ffa), .o_ff_exp(a_ffe),
    .o_ff_act(a_ffo)
  );

  bist_response_analyzer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(12), .READ_LATENCY(3), .CNT_WIDTH(4)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(t_start), .i_end_test(t_end), .i_cmp_en(t_cmp),
    .i_addr_in(t_addr), .i_exp_data(t_exp), .i_cmp_mask(t_mask), .i_mem_data(hist[2]),
    .o_busy(b_busy), .o_done(b_done), .o_fail(b_fail), .o_fail_pulse(b_pulse),
    .o_fail_count(b_cnt), .o_fail_bits(b_bits), .o_ff_addr(b_ffa), .o_ff_exp(b_ffe),
    .o_ff_act(b_ffo)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 accepting compares, 2 draining, 3 results final
  int          cyc;
  int          rl   [2];
  int          cmax [2];
  int          m_phase [2];
  int          m_end   [2];
  int          m_cnt   [2];
  logic        m_fail  [2];
  logic        m_pulse [2];
  logic [7:0]  m_bits  [2];
  logic [11:0] m_ffa   [2];
  logic [7:0]  m_ffe   [2];
  logic [7:0]  m_ffo   [2];
  // pending compares indexed by the cycle their data returns (mod 8)
  logic        p_v [2][8];
  logic [11:0] p_a [2][8];
  logic [7:0]  p_e [2][8];
  logic [7:0]  p_m [2][8];
  logic [7:0]  p_o [2][8];

  task automatic model_clear(input int i);
    m_fail[i] = 1'b0; m_pulse[i] = 1'b0; m_cnt[i] = 0; m_bits[i] = 8'h0;
    m_ffa[i] = 12'h0; m_ffe[i] = 8'h0; m_ffo[i] = 8'h0;
    for (int s = 0; s < 8; s++) p_v[i][s] = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      model_clear(i);
      m_phase[i] = 0;
      m_end[i]   = 0;
    end
  endtask

  task automatic model_edge(input int i);
    int         s;
    logic [7:0] mm;
    if (t_start) begin
      model_clear(i);
      m_phase[i] = 1;
    end else begin
      m_pulse[i] = 1'b0;
      s = cyc % 8;
      if (p_v[i][s]) begin
        p_v[i][s] = 1'b0;
        mm = (p_o[i][s] ^ p_e[i][s]) & ~p_m[i][s];
        if (mm != 8'h0) begin
          if (!m_fail[i] && FfEn) begin
            m_ffa[i] = p_a[i][s]; m_ffe[i] = p_e[i][s]; m_ffo[i] = p_o[i][s];
          end
          m_fail[i]  = 1'b1;
          m_pulse[i] = 1'b1;
          if (m_cnt[i] < cmax[i]) m_cnt[i]++;
          m_bits[i] = m_bits[i] | mm;
        end
      end
      if (m_phase[i] == 1 && t_cmp) begin
        s = (cyc + rl[i]) % 8;
        p_v[i][s] = 1'b1; p_a[i][s] = t_addr; p_e[i][s] = t_exp;
        p_m[i][s] = t_mask; p_o[i][s] = t_act;
      end
      if (m_phase[i] == 1 && t_end) begin
        m_phase[i] = 2;
        m_end[i]   = cyc;
      end else if (m_phase[i] == 2 && cyc + 1 == m_end[i] + rl[i] + 2) begin
        m_phase[i] = 3;
      end
    end
  endtask

  task automatic compare_model(input int i);
    logic [63:0] got, want;
    logic        bz, dn;
    logic [15:0] cnt16;
    bz    = (m_phase[i] == 1) || (m_phase[i] == 2);
    dn    = (m_phase[i] == 3);
    cnt16 = m_cnt[i][15:0];
    want  = {8'h0, bz, dn, m_fail[i], m_pulse[i], cnt16, m_bits[i], m_ffa[i], m_ffe[i], m_ffo[i]};
    if (i == 0) got = {8'h0, a_busy, a_done, a_fail, a_pulse, a_cnt, a_bits, a_ffa, a_ffe, a_ffo};
    else        got = {8'h0, b_busy, b_done, b_fail, b_pulse, 12'h0, b_cnt, b_bits, b_ffa, b_ffe,
                       b_ffo};
    check($sformatf("model_%s_cyc%0d", (i == 0) ? "a" : "b", cyc), got, want);
  endtask

  task automatic drive(input logic [2:0] ctl, input logic [11:0] a, input logic [7:0] e,
                       input logic [7:0] m, input logic [7:0] o);
    {t_start, t_end, t_cmp} = ctl;
    t_addr = a; t_exp = e; t_mask = m; t_act = o;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
    #1;
    compare_model(0);
    compare_model(1);
  endtask

  // ---------------- vector table (instance A, latency 1) ----------------
  typedef struct {
    logic [2:0]  ctl;
    logic [11:0] addr;
    logic [7:0]  exp, mask, act;
    logic [3:0]  stat;   // {busy, done, fail, fail_pulse} after the edge
    logic [15:0] cnt;
    logic [7:0]  bits;
    logic [11:0] ffa;
    logic [7:0]  ffe, ffo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic [2:0] ctl, logic [11:0] a, logic [7:0] e, logic [7:0] m,
                               logic [7:0] o, logic [3:0] st, logic [15:0] c, logic [7:0] b,
                               logic [11:0] fa, logic [7:0] fe, logic [7:0] fo);
    vec_t v;
    v.ctl = ctl; v.addr = a; v.exp = e; v.mask = m; v.act = o;
    v.stat = st; v.cnt = c; v.bits = b; v.ffa = fa; v.ffe = fe; v.ffo = fo;
    return v;
  endfunction

  initial begin
    logic [63:0] got, want;
    int          first_done;
    logic [2:0]  ctl;
    logic [7:0]  e;

    rl[0] = 1;     rl[1] = 3;
    cmax[0] = 65535; cmax[1] = 15;
    cyc = 0;
    model_reset();
    hist[0] = 8'h0; hist[1] = 8'h0; hist[2] = 8'h0;
    rst_n = 1'b0;
    drive(NOP, 12'h0, 8'h0, 8'h0, 8'h0);

    // Session 1: all compares pass
    tbl.push_back(mkv(ST, 12'h0, 8'h00, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mkv(CE, 12'(k), 8'h55, 8'h00, 8'h55, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(ET,  12'h0, 8'h00, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(NOP, 12'h0, 8'h00, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(NOP, 12'h0, 8'h00, 8'h00, 8'h00, 4'b0100, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(NOP, 12'h0, 8'h00, 8'h00, 8'h00, 4'b0100, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    // Session 2: two failures, first-failure capture, two pulses
    tbl.push_back(mkv(ST,  12'h0,   8'h00, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(CE,  12'h010, 8'h55, 8'h00, 8'h57, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(CE,  12'h020, 8'h55, 8'h00, 8'h45, 4'b1011, 1, 8'h02, 12'h010, 8'h55, 8'h57));
    tbl.push_back(mkv(NOP, 12'h0,   8'h00, 8'h00, 8'h00, 4'b1011, 2, 8'h12, 12'h010, 8'h55, 8'h57));
    tbl.push_back(mkv(NOP, 12'h0,   8'h00, 8'h00, 8'h00, 4'b1010, 2, 8'h12, 12'h010, 8'h55, 8'h57));
    tbl.push_back(mkv(ET,  12'h0,   8'h00, 8'h00, 8'h00, 4'b1010, 2, 8'h12, 12'h010, 8'h55, 8'h57));
    tbl.push_back(mkv(NOP, 12'h0,   8'h00, 8'h00, 8'h00, 4'b1010, 2, 8'h12, 12'h010, 8'h55, 8'h57));
    tbl.push_back(mkv(NOP, 12'h0,   8'h00, 8'h00, 8'h00, 4'b0110, 2, 8'h12, 12'h010, 8'h55, 8'h57));
    // Session 3: masking; partially masked pass, unmasked fail, fully masked pass
    tbl.push_back(mkv(ST,  12'h0,   8'h00, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(CE,  12'h000, 8'hFF, 8'hF0, 8'h0F, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(CE,  12'h001, 8'hFF, 8'h00, 8'h0F, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(CE,  12'h002, 8'h00, 8'hFF, 8'hFF, 4'b1011, 1, 8'hF0, 12'h001, 8'hFF, 8'h0F));
    tbl.push_back(mkv(NOP, 12'h0,   8'h00, 8'h00, 8'h00, 4'b1010, 1, 8'hF0, 12'h001, 8'hFF, 8'h0F));
    tbl.push_back(mkv(NOP, 12'h0,   8'h00, 8'h00, 8'h00, 4'b1010, 1, 8'hF0, 12'h001, 8'hFF, 8'h0F));
    // start+end_test together: start wins, stays active
    tbl.push_back(mkv(ST | ET, 12'h0, 8'h00, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(NOP, 12'h0, 8'h00, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(NOP, 12'h0, 8'h00, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    // cmp_en in the start cycle is ignored
    tbl.push_back(mkv(ST | CE, 12'h5, 8'h00, 8'h00, 8'hFF, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(NOP, 12'h0, 8'h00, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(NOP, 12'h0, 8'h00, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(ET,  12'h0, 8'h00, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(NOP, 12'h0, 8'h00, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 12'h0, 8'h00, 8'h00));
    tbl.push_back(mkv(NOP, 12'h0, 8'h00, 8'h00, 8'h00, 4'b0100, 0, 8'h00, 12'h0, 8'h00, 8'h00));

    // Reset state
    #3;
    check("reset_a", {8'h0, a_busy, a_done, a_fail, a_pulse, a_cnt, a_bits, a_ffa, a_ffe, a_ffo},
          64'h0);
    check("reset_b", {8'h0, b_busy, b_done, b_fail, b_pulse, 12'h0, b_cnt, b_bits, b_ffa, b_ffe,
                      b_ffo}, 64'h0);
    #9 rst_n = 1'b1;

    foreach (tbl[r]) begin
      drive(tbl[r].ctl, tbl[r].addr, tbl[r].exp, tbl[r].mask, tbl[r].act);
      tick();
      got  = {8'h0, a_busy, a_done, a_fail, a_pulse, a_cnt, a_bits, a_ffa, a_ffe, a_ffo};
      want = {8'h0, tbl[r].stat, tbl[r].cnt, tbl[r].bits,
              FfEn ? tbl[r].ffa : 12'h0, FfEn ? tbl[r].ffe : 8'h0, FfEn ? tbl[r].ffo : 8'h0};
      check($sformatf("vec%0d", r), got, want);
    end

    // Saturation: 20 failing compares
    drive(ST, 12'h0, 8'h00, 8'h00, 8'h00); tick();
    for (int k = 0; k < 20; k++) begin
      drive(CE, 12'(k + 12'h100), 8'h00, 8'h00, 8'h01); tick();
    end
    drive(ET, 12'h0, 8'h00, 8'h00, 8'h00); tick();
    drive(NOP, 12'h0, 8'h00, 8'h00, 8'h00);
    for (int n = 0; n < 12 && !(a_done && b_done); n++) tick();
    check("sat_b", {59'h0, b_done, b_fail, b_cnt[1:0] ^ 2'b00, 1'b0} | {60'h0, b_cnt},
          {59'h0, 1'b1, 1'b1, 2'b11, 1'b0} | 64'hF);
    check("sat_a_cnt", {48'h0, a_cnt}, 64'd20);
    check("sat_ff_addr", {52'h0, b_ffa}, FfEn ? 64'h100 : 64'h0);

    // Latency 3: alternating pass/fail, end_test with the last compare
    drive(ST, 12'h0, 8'h00, 8'h00, 8'h00); tick();
    for (int k = 0; k < 6; k++) begin
      ctl = (k == 5) ? (CE | ET) : CE;
      e   = (k % 2 == 1) ? 8'hAB : 8'hAA;
      drive(ctl, 12'(k + 12'h200), 8'hAA, 8'h00, e); tick();
    end
    drive(NOP, 12'h0, 8'h00, 8'h00, 8'h00);
    first_done = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 3) check("lat3_pre_done", {59'h0, b_done, b_cnt}, {59'h0, 1'b0, 4'd3});
      if (b_done && first_done == 0) first_done = n;
    end
    check("lat3_done_cycle", 64'(first_done), 64'd4);
    check("lat3_bits", {56'h0, b_bits}, 64'h01);

    // Asynchronous reset mid-session with failures logged
    drive(ST, 12'h0, 8'h00, 8'h00, 8'h00); tick();
    for (int k = 0; k < 3; k++) begin
      drive(CE, 12'(k), 8'h0F, 8'h00, 8'hF0); tick();
    end
    drive(NOP, 12'h0, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) tick();
    check("pre_rst_fail", {62'h0, a_fail, b_fail}, 64'h3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_a", {8'h0, a_busy, a_done, a_fail, a_pulse, a_cnt, a_bits, a_ffa, a_ffe, a_ffo},
          64'h0);
    check("rst_b", {8'h0, b_busy, b_done, b_fail, b_pulse, 12'h0, b_cnt, b_bits, b_ffa, b_ffe,
                    b_ffo}, 64'h0);
    #3 rst_n = 1'b1;
    tick();
    drive(ST, 12'h0, 8'h00, 8'h00, 8'h00); tick();
    drive(ET, 12'h0, 8'h00, 8'h00, 8'h00); tick();
    drive(NOP, 12'h0, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 6; k++) tick();
    check("empty_session", {60'h0, a_done, b_done, a_fail, b_fail}, 64'hC);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      ctl = {($urandom % 40) == 0, ($urandom % 30) == 0, ($urandom % 10) < 7};
      e   = 8'($urandom);
      drive(ctl, 12'($urandom), e,
            (($urandom % 4) == 0) ? 8'($urandom) : ((($urandom % 16) == 0) ? 8'hFF : 8'h00),
            (($urandom % 3) == 0) ? (e ^ 8'($urandom)) : e);
      tick();
    end
    drive(ST, 12'h0, 8'h00, 8'h00, 8'h00); tick();
    drive(ET, 12'h0, 8'h00, 8'h00, 8'h00); tick();
    drive(NOP, 12'h0, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) tick();
    check("final_done", {62'h0, a_done, b_done}, 64'h3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
